pipeline_memory: RTL and testbench
==================================

// Module: pipeline_memory
// PURPOSE
//  Memory pipeline stage. Sits after the execute stage and is the producer side of the
//  execute-stage forwarding/hazard interface (memory_done/is_dependent/result/instr).
//  Passes ALU results through in one cycle; runs loads/stores over a req/ack data-memory
//  port; stalls upstream while a transfer is outstanding; flags a sticky error on ack timeout.
// PARAMETERS
//  TIMEOUT_CYCLES  255      max WAIT cycles before forced completion; 0 = no timeout
//  ERR_DATA        16'hDEAD load result returned on timeout
// PORTS
//  clk                  in   1   clock; all state updates on posedge
//  reset                in   1   synchronous, active-low (0 = reset)
//  execute_instr        in   16  instruction from execute stage; 16'h0000 = bubble
//  execute_result       in   16  ALU result; used as address for load/store
//  execute_store_data   in   16  store write data (regfile value of execute_instr[2:0])
//  execute_done         in   1   execute result final (ALU op)
//  execute_is_dependent in   1   execute instr writes instr[2:0]
//  memory_stall         out  1   upstream must hold its outputs this cycle
//  memory_done          out  1   memory_result is final
//  memory_is_dependent  out  1   memory_instr writes register memory_instr[2:0]
//  memory_result        out  16  ALU passthrough or load data
//  memory_instr         out  16  instruction currently in stage
//  mem_req              out  1   data-memory request, held until ack
//  mem_we               out  1   1 = store, 0 = load
//  mem_addr             out  16  memory address
//  mem_wdata            out  16  store data
//  mem_ack              in   1   memory completes request this cycle
//  mem_rdata            in   16  load data, valid with mem_ack
//  mem_error            out  1   sticky; set on timeout, cleared only by reset
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE, all registered outputs and counter = 0;
//    memory_stall=0. Applies mid-WAIT: mem_req drops at that edge; a later ack is ignored.
//  - FSM states: IDLE, WAIT. memory_stall = (state==WAIT), combinational; includes ack cycle.
//  - IDLE, non-memory instr (incl. bubble): next edge memory_instr<=execute_instr,
//    memory_result<=execute_result, memory_done<=execute_done,
//    memory_is_dependent<=execute_is_dependent. Latency 1 cycle; stay IDLE.
//  - IDLE, LOAD (instr[15:12]==`LOAD_OP): next edge memory_instr<=instr, done<=0,
//    is_dependent<=1, result<=0, mem_req<=1, mem_we<=0, mem_addr<=execute_result -> WAIT.
//  - IDLE, STORE (`STORE_OP): as LOAD but is_dependent<=0, mem_we<=1,
//    mem_wdata<=execute_store_data.
//  - WAIT, mem_ack==0: hold all outputs; counter++.
//  - WAIT, mem_ack==1: next edge mem_req<=0, memory_done<=1, load: memory_result<=mem_rdata;
//    counter<=0 -> IDLE. Next instr accepted in the first IDLE cycle after.
//    Load-to-done latency = 1 + N cycles, N = cycles until ack (N>=1).
//  - Timeout: WAIT and counter==TIMEOUT_CYCLES-1 with no ack: complete as with ack using
//    ERR_DATA for loads; mem_error<=1. Ack and timeout in same cycle: ack wins, no error.
//  - mem_ack while IDLE: ignored. mem_addr/mem_wdata/mem_we stable for whole request.
//  - Counter width $clog2(TIMEOUT_CYCLES+1); saturates, never wraps.
// STRUCTURE
//  - Constant.sv: `LOAD_OP 4'b1000, `STORE_OP 4'b1001, `NOOP 16'h0000, FSM state
//    encodings (IDLE, WAIT).
//  - One sub-module: mem_timeout_counter (clear, enable, expired; param TIMEOUT_CYCLES).
//  - Top: FSM, stage registers, memory-port registers, stall logic.
// TESTING
//  1 ALU passthrough: instr=16'h4A1B, result=16'h1234, done=1, dep=1 -> next cycle
//    memory_* = same values, memory_stall=0, mem_req=0.
//  2 Load, ack after 3 cycles, rdata=16'hBEEF, addr=16'h0040 -> mem_req 1 for 3 cycles,
//    mem_addr=16'h0040, memory_done=0/is_dependent=1 while stalled, then done=1,
//    result=16'hBEEF.
//  3 Store addr=16'h0010, data=16'h00FF, ack after 1 cycle -> mem_we=1, wdata=16'h00FF,
//    is_dependent=0 throughout, done=1 after ack, no writeback value.
//  4 Timeout: TIMEOUT_CYCLES=4, load never acked -> after 4 WAIT cycles result=16'hDEAD,
//    done=1, mem_error=1 and stays 1 until reset.
//  5 Reset in WAIT: reset=0 two cycles into a load -> all outputs 0 next edge; ack one cycle
//    later ignored, state IDLE.
//  6 Back-to-back load then ALU op held by upstream during stall -> ALU op appears exactly one
//    cycle after load shows done=1; nothing lost or duplicated.

Source files
------------

// File: rtl/pipeline_memory_pkg.sv
// Shared opcodes, bubble encoding and FSM state type for the memory pipeline stage.
package pipeline_memory_pkg;

  localparam logic [3:0]  LOAD_OP  = 4'b1000;
  localparam logic [3:0]  STORE_OP = 4'b1001;
  localparam logic [15:0] NOOP     = 16'h0000;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == LOAD_OP) || (op == STORE_OP);
  endfunction

endpackage

// File: rtl/pipeline_memory_if.sv
// Data-memory req/ack port: the stage is the master, the memory is the slave.
interface pipeline_memory_if;

  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        ack;
  logic [15:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);

endinterface

// File: rtl/pipeline_memory_timeout.sv
// Saturating wait-cycle counter; expired marks the last WAIT cycle allowed before a forced completion.
module mem_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_TC  = (TIMEOUT_CYCLES < 1) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

  // A zero timeout disables forced completion entirely.
  assign expired = (TIMEOUT_CYCLES != 0) && (count == CNT_TC);

endmodule

// File: rtl/pipeline_memory.sv
// Memory pipeline stage: one-cycle ALU passthrough, loads/stores over a req/ack port with timeout.
// state | meaning
// IDLE  | accepting a new instruction from execute every cycle
// WAIT  | load/store outstanding on the memory port; upstream stalled
module pipeline_memory
  import pipeline_memory_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [15:0] ERR_DATA       = 16'hDEAD
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [15:0]               execute_instr,
  input  logic [15:0]               execute_result,
  input  logic [15:0]               execute_store_data,
  input  logic                      execute_done,
  input  logic                      execute_is_dependent,
  output logic                      memory_stall,
  output logic                      memory_done,
  output logic                      memory_is_dependent,
  output logic [15:0]               memory_result,
  output logic [15:0]               memory_instr,
  pipeline_memory_if.master         mem,
  output logic                      mem_error
);

  state_t      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] result_q, result_d;
  logic        done_q, done_d;
  logic        dep_q, dep_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic        cnt_clear, cnt_en, cnt_expired;
  logic [3:0]  exec_op;

  assign exec_op = execute_instr[15:12];

  mem_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .expired (cnt_expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      instr_q  <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      dep_q    <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      done_q   <= done_d;
      dep_q    <= dep_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    result_d  = result_q;
    done_d    = done_q;
    dep_d     = dep_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;

    unique case (state_q)
      IDLE: begin
        instr_d = execute_instr;
        if (is_mem_op(exec_op)) begin
          result_d  = '0;
          done_d    = 1'b0;
          dep_d     = (exec_op == LOAD_OP);
          req_d     = 1'b1;
          we_d      = (exec_op == STORE_OP);
          addr_d    = execute_result;
          if (exec_op == STORE_OP) begin
            wdata_d = execute_store_data;
          end
          cnt_clear = 1'b1;
          state_d   = WAIT;
        end else begin
          result_d = execute_result;
          done_d   = execute_done;
          dep_d    = execute_is_dependent;
        end
      end

      WAIT: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (mem.ack || cnt_expired) begin
          req_d     = 1'b0;
          done_d    = 1'b1;
          cnt_clear = 1'b1;
          state_d   = IDLE;
          if (!we_q) begin
            result_d = mem.ack ? mem.rdata : ERR_DATA;
          end
          if (!mem.ack) begin
            err_d = 1'b1;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign memory_stall        = (state_q == WAIT);
  assign memory_done         = done_q;
  assign memory_is_dependent = dep_q;
  assign memory_result       = result_q;
  assign memory_instr        = instr_q;
  assign mem.req             = req_q;
  assign mem.we              = we_q;
  assign mem.addr            = addr_q;
  assign mem.wdata           = wdata_q;
  assign mem_error           = err_q;

endmodule

// File: tb/tb_pipeline_memory.sv
// Directed bench for pipeline_memory: transaction-level model checked every cycle plus literal spot checks.
module tb_pipeline_memory;
  import pipeline_memory_pkg::*;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] execute_instr = '0;
  logic [15:0] execute_result = '0;
  logic [15:0] execute_store_data = '0;
  logic        execute_done = 1'b0;
  logic        execute_is_dependent = 1'b0;
  logic        memory_stall, memory_done, memory_is_dependent, mem_error;
  logic [15:0] memory_result, memory_instr;

  int n_checks = 0;
  int n_errors = 0;
  int alu_seen = 0;
  logic cmp_en = 1'b0;

  pipeline_memory_if mem_bus ();

  pipeline_memory #(
    .TIMEOUT_CYCLES (T),
    .ERR_DATA       (16'hDEAD)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .execute_instr        (execute_instr),
    .execute_result       (execute_result),
    .execute_store_data   (execute_store_data),
    .execute_done         (execute_done),
    .execute_is_dependent (execute_is_dependent),
    .memory_stall         (memory_stall),
    .memory_done          (memory_done),
    .memory_is_dependent  (memory_is_dependent),
    .memory_result        (memory_result),
    .memory_instr         (memory_instr),
    .mem                  (mem_bus.master),
    .mem_error            (mem_error)
  );

  always #5 clk = ~clk;

  // Transaction-level reference: an outstanding request plus the number of cycles it has waited.
  logic [15:0] m_instr, m_result, m_addr, m_wdata;
  logic        m_done, m_dep, m_req, m_we, m_err, m_busy;
  int          m_waited;

  always @(posedge clk) begin
    if (!reset) begin
      m_instr = '0; m_result = '0; m_addr = '0; m_wdata = '0;
      m_done = 0; m_dep = 0; m_req = 0; m_we = 0; m_err = 0; m_busy = 0;
      m_waited = 0;
    end else if (!m_busy) begin
      m_instr = execute_instr;
      if (execute_instr[15:12] == LOAD_OP || execute_instr[15:12] == STORE_OP) begin
        m_we     = (execute_instr[15:12] == STORE_OP);
        m_dep    = !m_we;
        m_done   = 0;
        m_result = '0;
        m_req    = 1;
        m_addr   = execute_result;
        if (m_we) m_wdata = execute_store_data;
        m_busy   = 1;
        m_waited = 0;
      end else begin
        m_result = execute_result;
        m_done   = execute_done;
        m_dep    = execute_is_dependent;
      end
    end else begin
      m_waited = m_waited + 1;
      if (mem_bus.ack) begin
        m_req = 0; m_done = 1; m_busy = 0;
        if (!m_we) m_result = mem_bus.rdata;
      end else if (T != 0 && m_waited == T) begin
        m_req = 0; m_done = 1; m_busy = 0; m_err = 1;
        if (!m_we) m_result = 16'hDEAD;
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("stall",  16'(memory_stall),        16'(m_busy));
      chk("done",   16'(memory_done),         16'(m_done));
      chk("dep",    16'(memory_is_dependent), 16'(m_dep));
      chk("result", memory_result,            m_result);
      chk("instr",  memory_instr,             m_instr);
      chk("req",    16'(mem_bus.req),         16'(m_req));
      chk("we",     16'(mem_bus.we),          16'(m_we));
      chk("addr",   mem_bus.addr,             m_addr);
      chk("wdata",  mem_bus.wdata,            m_wdata);
      chk("error",  16'(mem_error),           16'(m_err));
      if (memory_instr == 16'h3E07) alu_seen++;
    end
  end

  task automatic cycle(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_exec(input logic [15:0] instr, input logic [15:0] res,
                          input logic [15:0] sdata, input logic done, input logic dep);
    execute_instr        = instr;
    execute_result       = res;
    execute_store_data   = sdata;
    execute_done         = done;
    execute_is_dependent = dep;
  endtask

  task automatic bubble();
    set_exec(NOOP, 16'h0000, 16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    mem_bus.ack   = 1'b0;
    mem_bus.rdata = 16'h0000;
    bubble();
    reset = 1'b0;
    cycle(2);
    chk("rst_instr", memory_instr, 16'h0000);
    chk("rst_stall", 16'(memory_stall), 16'h0000);
    chk("rst_req",   16'(mem_bus.req), 16'h0000);
    reset = 1'b1;
    cmp_en = 1'b1;

    // ALU passthrough
    set_exec(16'h4A1B, 16'h1234, 16'h0000, 1'b1, 1'b1);
    cycle();
    chk("alu_instr",  memory_instr, 16'h4A1B);
    chk("alu_result", memory_result, 16'h1234);
    chk("alu_done",   16'(memory_done), 16'h0001);
    chk("alu_dep",    16'(memory_is_dependent), 16'h0001);
    chk("alu_stall",  16'(memory_stall), 16'h0000);
    chk("alu_req",    16'(mem_bus.req), 16'h0000);

    // Load acked in the third WAIT cycle
    set_exec(16'h8A05, 16'h0040, 16'h0000, 1'b0, 1'b1);
    cycle();
    bubble();
    chk("ld_req1",  16'(mem_bus.req), 16'h0001);
    chk("ld_addr",  mem_bus.addr, 16'h0040);
    chk("ld_done0", 16'(memory_done), 16'h0000);
    chk("ld_dep",   16'(memory_is_dependent), 16'h0001);
    cycle(2);
    chk("ld_req3",  16'(mem_bus.req), 16'h0001);
    mem_bus.ack   = 1'b1;
    mem_bus.rdata = 16'hBEEF;
    cycle();
    mem_bus.ack   = 1'b0;
    chk("ld_done1",  16'(memory_done), 16'h0001);
    chk("ld_result", memory_result, 16'hBEEF);
    chk("ld_req_off", 16'(mem_bus.req), 16'h0000);
    chk("ld_stall0", 16'(memory_stall), 16'h0000);

    // Store acked in the first WAIT cycle
    set_exec(16'h9A03, 16'h0010, 16'h00FF, 1'b0, 1'b0);
    cycle();
    bubble();
    chk("st_we",    16'(mem_bus.we), 16'h0001);
    chk("st_wdata", mem_bus.wdata, 16'h00FF);
    chk("st_dep",   16'(memory_is_dependent), 16'h0000);
    mem_bus.ack = 1'b1;
    cycle();
    mem_bus.ack = 1'b0;
    chk("st_done",   16'(memory_done), 16'h0001);
    chk("st_result", memory_result, 16'h0000);

    // Ack arriving on the last allowed WAIT cycle beats the timeout
    set_exec(16'h8B01, 16'h0077, 16'h0000, 1'b0, 1'b1);
    cycle();
    bubble();
    cycle(3);
    mem_bus.ack   = 1'b1;
    mem_bus.rdata = 16'h1357;
    cycle();
    mem_bus.ack   = 1'b0;
    chk("edge_result", memory_result, 16'h1357);
    chk("edge_err",    16'(mem_error), 16'h0000);

    // Load never acked: forced completion with error data
    set_exec(16'h8C02, 16'h0020, 16'h0000, 1'b0, 1'b1);
    cycle();
    bubble();
    cycle(3);
    chk("to_stall4", 16'(memory_stall), 16'h0001);
    cycle();
    chk("to_result", memory_result, 16'hDEAD);
    chk("to_done",   16'(memory_done), 16'h0001);
    chk("to_err",    16'(mem_error), 16'h0001);
    set_exec(16'h2123, 16'h0042, 16'h0000, 1'b1, 1'b1);
    cycle(3);
    bubble();
    chk("to_err_sticky", 16'(mem_error), 16'h0001);

    // Reset two cycles into a load; the late ack must be ignored
    set_exec(16'h8D04, 16'h0030, 16'h0000, 1'b0, 1'b1);
    cycle();
    bubble();
    cycle();
    reset = 1'b0;
    cycle();
    chk("rw_req",   16'(mem_bus.req), 16'h0000);
    chk("rw_stall", 16'(memory_stall), 16'h0000);
    chk("rw_err",   16'(mem_error), 16'h0000);
    chk("rw_instr", memory_instr, 16'h0000);
    reset = 1'b1;
    mem_bus.ack   = 1'b1;
    mem_bus.rdata = 16'hFFFF;
    cycle();
    mem_bus.ack   = 1'b0;
    chk("rw_ack_ign_done",   16'(memory_done), 16'h0000);
    chk("rw_ack_ign_result", memory_result, 16'h0000);
    chk("rw_ack_ign_stall",  16'(memory_stall), 16'h0000);

    // Load followed by an ALU op held upstream through the stall
    set_exec(16'h8E06, 16'h0050, 16'h0000, 1'b0, 1'b1);
    cycle();
    set_exec(16'h3E07, 16'h5555, 16'h0000, 1'b1, 1'b1);
    cycle();
    mem_bus.ack   = 1'b1;
    mem_bus.rdata = 16'hA5A5;
    cycle();
    mem_bus.ack   = 1'b0;
    chk("b2b_ld_instr",  memory_instr, 16'h8E06);
    chk("b2b_ld_result", memory_result, 16'hA5A5);
    cycle();
    bubble();
    chk("b2b_alu_instr",  memory_instr, 16'h3E07);
    chk("b2b_alu_result", memory_result, 16'h5555);
    cycle(2);
    chk("b2b_alu_once", 16'(alu_seen), 16'h0001);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
